// File: rtl/adder_pkg.sv
// Shared sizing helpers and saturation constants for the pipelined adder.
// Pure elaboration-time functions; no hardware of their own.
package adder_pkg;

    localparam int MAX_W = 64;

    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (width % stages == 0) && (width <= MAX_W);
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for the pipelined adder: valid/ready in, valid/ready out.
// slave = adder side, master = producer/consumer side.
interface pipelined_adder_if #(parameter int WIDTH = 16);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    modport slave (
        input  valid_i, a_i, b_i, cin_i, sub_i, ready_i,
        output ready_o, valid_o, sum_o, cout_o, ovf_o
    );

    modport master (
        output valid_i, a_i, b_i, cin_i, sub_i, ready_i,
        input  ready_o, valid_o, sum_o, cout_o, ovf_o
    );
endinterface

// File: rtl/adder_segment.sv
// Combinational SEG_W-bit ripple-carry segment; zero latency, no flow control.
module adder_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             cout_o
);
    logic [SEG_W:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < SEG_W; i++) begin
            sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[SEG_W];
    end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/sub, one ripple segment per stage; latency STAGES, whole pipe stalls while valid_o && !ready_i.
// PIPELINED_ADDER_SAT_EN: clamp sum_o to the signed limit on overflow.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipelined_adder_if.slave  bus
);
    localparam int SEG_W = seg_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

`ifdef PIPELINED_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

    logic             en;
    logic             vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Per-stage inputs: index 0 is the port, index k>0 is stage k-1's register.
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    assign en          = !vld_q || bus.ready_i;
    assign bus.ready_o = en;
    assign bus.valid_o = vld_q;
    assign bus.sum_o   = sum_q;
    assign bus.cout_o  = cout_q;
    assign bus.ovf_o   = ovf_q;

    assign a_in[0] = bus.a_i;
    assign b_in[0] = bus.sub_i ? ~bus.b_i : bus.b_i;
    assign c_in[0] = bus.cin_i ^ bus.sub_i;
    assign s_in[0] = '0;
    assign v_in[0] = bus.valid_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG_W-1:0] seg_sum;
        logic             seg_cout;
        logic [WIDTH-1:0] s_d;

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a_i    (a_in[k][k*SEG_W +: SEG_W]),
            .b_i    (b_in[k][k*SEG_W +: SEG_W]),
            .cin_i  (c_in[k]),
            .sum_o  (seg_sum),
            .cout_o (seg_cout)
        );

        always_comb begin
            s_d                     = s_in[k];
            s_d[k*SEG_W +: SEG_W]   = seg_sum;
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            // Data registers need no reset: v_q gates everything downstream.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v_q <= 1'b0;
                end else if (en) begin
                    v_q <= v_in[k];
                    a_q <= a_in[k];
                    b_q <= b_in[k];
                    s_q <= s_d;
                    c_q <= seg_cout;
                end
            end

            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
            assign s_in[k+1] = s_q;
            assign c_in[k+1] = c_q;
            assign v_in[k+1] = v_q;
        end else begin : g_last
            logic             ovf_d;
            logic [WIDTH-1:0] res_d;

            assign ovf_d = (a_in[k][WIDTH-1] == b_in[k][WIDTH-1]) &&
                           (s_d[WIDTH-1] != a_in[k][WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
            assign res_d = ovf_d ? (a_in[k][WIDTH-1] ? SAT_MIN : SAT_MAX) : s_d;
`else
            assign res_d = s_d;
`endif

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q  <= 1'b0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (en) begin
                    vld_q  <= v_in[k];
                    sum_q  <= res_d;
                    cout_q <= seg_cout;
                    ovf_q  <= ovf_d;
                end
            end
        end
    end
endmodule
